fc_input_layer: RTL and testbench
=================================

FC_INPUT_LAYER -- requirements
Module: fc_input_layer

Interface
REQ-001 SHALL have parameter LAYER_HEIGHT, default 5, meaning the number of words per assembled vector (at least 2).
REQ-002 SHALL have parameter WORD_SIZE, default 16, meaning the bit width of one word.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ren_o, output, 1 bit: pop request to the upstream first-word-fall-through FIFO.
REQ-006 SHALL have port empty_i, input, 1 bit: upstream FIFO empty flag.
REQ-007 SHALL have port data_i, input, WORD_SIZE bits: FIFO head word, valid whenever empty_i is low.
REQ-008 SHALL have port valid_o, output, 1 bit: the assembled vector on data_o is valid.
REQ-009 SHALL have port ready_i, input, 1 bit: the next layer accepts the vector.
REQ-010 SHALL have port data_o, output, LAYER_HEIGHT x WORD_SIZE bits (packed [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]): the assembled vector.

Function
REQ-011 SHALL pop a word only on a cycle where ren_o=1 and empty_i=0 (a "pop"); ren_o SHALL never be 1 while empty_i=1.
REQ-012 SHALL store the k-th popped word of a vector, with k counting from 0, at data_o[k]; the first word popped SHALL land at index 0.
REQ-013 SHALL use a word address counter from 0 to LAYER_HEIGHT-1 that increments on each pop and wraps to 0 on the pop at LAYER_HEIGHT-1.
REQ-014 SHALL have two states, eFILL and eVALID, with valid_o=1 exactly when the state is eVALID.
REQ-015 SHALL move eFILL to eVALID on the pop at address LAYER_HEIGHT-1, so valid_o rises on the cycle after the last pop (latency 1).
REQ-016 SHALL move eVALID to eFILL on the cycle valid_o=1 and ready_i=1; otherwise it SHALL remain in eVALID.
REQ-017 SHALL hold data_o stable while valid_o=1 and ready_i=0.
REQ-018 SHALL drive data_o to all zeros while valid_o=0.
REQ-019 SHALL not change the address counter or stored words while empty_i=1 (stall); stall cycles between pops SHALL be allowed and SHALL not affect the result.
REQ-020 SHALL ignore ready_i while valid_o=0.

Reset
REQ-021 SHALL, on a cycle with reset_i=1, set the state to eFILL, the address to 0, valid_o=0, data_o to all zeros and any pending-fill flag to 0.
REQ-022 SHALL, on reset during a partial fill or while a vector is held, discard the partial or held vector, with no pop on the reset cycle (ren_o=0).

Configuration
REQ-023 SHALL, with macro FC_INPUT_LAYER_DOUBLE_BUFFER_EN undefined, drive ren_o = (state==eFILL) && ~empty_i, so no pops occur while valid_o=1.
REQ-024 SHALL, with FC_INPUT_LAYER_DOUBLE_BUFFER_EN defined, add a fill buffer so that ren_o = ~empty_i && ~fill_pending and filling continues while valid_o=1.
REQ-025 SHALL, when double-buffered, load the output register directly with the completed vector (including the final word) on the last pop if valid_o=0 or ready_i=1; valid_o SHALL then be 1 on the next cycle.
REQ-026 SHALL, when double-buffered, set fill_pending on the last pop if valid_o=1 and ready_i=0; fill_pending stops pops until the handshake, then the fill buffer transfers to the output on the ready_i cycle and fill_pending clears.
REQ-027 SHALL, when double-buffered, sustain one vector per LAYER_HEIGHT cycles with a continuously non-empty FIFO and ready_i=1.

Verification (LAYER_HEIGHT=5, WORD_SIZE=16)
REQ-028 SHALL cover: empty_i=0, data_i=1,2,3,4,5 on consecutive cycles, ready_i=1 -> valid_o high one cycle after the 5th pop; data_o[0..4]=1..5; valid_o low the next cycle.
REQ-029 SHALL cover: empty_i toggling 1/0 every cycle during a fill -> exactly 5 pops, ren_o=0 on every empty cycle, data_o correct.
REQ-030 SHALL cover: ready_i=0 for 10 cycles after valid_o rises -> data_o stable, valid_o held; without the macro ren_o=0 throughout.
REQ-031 SHALL cover: reset_i pulsed after 3 pops, then words 9..13 -> data_o[0..4]=9..13 and no residue of the earlier words.
REQ-032 SHALL cover: macro defined, continuous FIFO data 1..15, ready_i=1 -> three vectors on cycles 6, 11 and 16 after the first pop.
REQ-033 SHALL cover: macro defined, ready_i=0 until the second vector completes -> ren_o drops, and the second vector appears the cycle after ready_i=1.

Source files
------------

// File: rtl/fc_input_layer.sv
// Assembles LAYER_HEIGHT words popped from a FWFT FIFO into one vector handed off with valid/ready.
// Optional macro FC_INPUT_LAYER_DOUBLE_BUFFER_EN adds a fill buffer so popping overlaps the output hold.
module fc_input_layer #(
    parameter int LAYER_HEIGHT = 5,
    parameter int WORD_SIZE    = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    output logic                                   ren_o,
    input  logic                                   empty_i,
    input  logic [WORD_SIZE-1:0]                   data_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o
);

    localparam int AW = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(LAYER_HEIGHT - 1);

    localparam logic [0:0] eFILL  = 1'b0;
    localparam logic [0:0] eVALID = 1'b1;

    logic [0:0]                             state;
    logic [AW-1:0]                          addr;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] out_words;
    logic                                   pop;
    logic                                   last;
    logic                                   accept;

    assign valid_o = (state == eVALID);
    assign accept  = valid_o && ready_i;
    assign last    = (addr == LAST_ADDR);
    assign pop     = ren_o;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            addr <= '0;
        else if (pop)
            addr <= last ? '0 : addr + AW'(1);
    end

`ifdef FC_INPUT_LAYER_DOUBLE_BUFFER_EN
    logic                                   fill_pending;
    logic                                   load_direct;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] fill_words;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] full_words;

    // ren_o already implies ~empty_i, so it doubles as the pop strobe
    assign ren_o       = ~reset_i && ~empty_i && ~fill_pending;
    assign load_direct = pop && last && (!valid_o || ready_i);

    // completed vector as it will look once the word at the head lands
    always_comb begin
        full_words       = fill_words;
        full_words[addr] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= eFILL;
            fill_pending <= 1'b0;
        end else if (load_direct) begin
            state <= eVALID;
        end else if (pop && last) begin
            fill_pending <= 1'b1;
        end else if (accept) begin
            if (fill_pending)
                fill_pending <= 1'b0;
            else
                state <= eFILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop)
            fill_words[addr] <= data_i;
        if (load_direct)
            out_words <= full_words;
        else if (accept && fill_pending)
            out_words <= fill_words;
    end
`else
    assign ren_o = ~reset_i && (state == eFILL) && ~empty_i;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state <= eFILL;
        else if (pop && last)
            state <= eVALID;
        else if (accept)
            state <= eFILL;
    end

    // no pops happen while the vector is held, so words assemble in place
    always_ff @(posedge clk_i) begin
        if (pop)
            out_words[addr] <= data_i;
    end
`endif

    assign data_o = valid_o ? out_words : '0;

endmodule

// File: tb/tb_fc_input_layer.sv
// Bench for fc_input_layer: cycle table, directed corner sequences, then random traffic vs a vector-FIFO model.
module tb_fc_input_layer;

    localparam int H  = 5;
    localparam int W  = 16;
    localparam int DW = H * W;
`ifdef FC_INPUT_LAYER_DOUBLE_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic                  ren_o;
    logic                  empty_i;
    logic [W-1:0]          data_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [H-1:0][W-1:0]   data_o;

    fc_input_layer #(.LAYER_HEIGHT(H), .WORD_SIZE(W)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .ren_o   (ren_o),
        .empty_i (empty_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pops   = 0;

    logic [W-1:0]  src[$];   // upstream FIFO contents
    logic [W-1:0]  cur[$];   // model: words of the vector being assembled
    logic [DW-1:0] vq[$];    // model: completed vectors not yet accepted

    typedef struct {
        logic          e;
        logic [W-1:0]  d;
        logic          r;
        logic          x_ren;
        logic          x_valid;
        logic [DW-1:0] x_data;
    } row_t;

    row_t tbl[7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, check against the model, advance the model.
    task automatic drive(input logic e, input logic [W-1:0] d, input logic r, input logic rst,
                         output logic popped);
        logic          x_ren;
        logic          x_valid;
        logic [DW-1:0] x_data;
        logic [DW-1:0] vec;
        @(negedge clk);
        empty_i = e; data_i = d; ready_i = r; reset_i = rst;
        #1;
        x_ren   = !rst && !e && (vq.size() < CAP);
        x_valid = (vq.size() > 0);
        x_data  = x_valid ? vq[0] : '0;
        chk("ren", {79'd0, ren_o}, {79'd0, x_ren});
        chk("valid", {79'd0, valid_o}, {79'd0, x_valid});
        chk("data", data_o, x_data);
        popped = (ren_o === 1'b1) && !e;
        if (popped) pops++;
        if (rst) begin
            cur.delete();
            vq.delete();
        end else begin
            if (x_valid && r) void'(vq.pop_front());
            if (x_ren) begin
                cur.push_back(d);
                if (cur.size() == H) begin
                    vec = '0;
                    for (int k = 0; k < H; k++) vec[k*W +: W] = cur[k];
                    vq.push_back(vec);
                    cur.delete();
                end
            end
        end
    endtask

    task automatic fstep(input logic hide, input logic r, input logic rst);
        logic         p;
        logic         e;
        logic [W-1:0] d;
        e = hide || (src.size() == 0);
        if (src.size() != 0) d = src[0];
        else d = W'($urandom);
        drive(e, d, r, rst, p);
        if (p && src.size() != 0) void'(src.pop_front());
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) fstep(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic          p;
        logic          got;
        logic [DW-1:0] held;
        int            base_pops;

        tbl[0] = '{1'b0, 16'd1, 1'b1, 1'b1, 1'b0, '0};
        tbl[1] = '{1'b0, 16'd2, 1'b1, 1'b1, 1'b0, '0};
        tbl[2] = '{1'b0, 16'd3, 1'b1, 1'b1, 1'b0, '0};
        tbl[3] = '{1'b0, 16'd4, 1'b1, 1'b1, 1'b0, '0};
        tbl[4] = '{1'b0, 16'd5, 1'b1, 1'b1, 1'b0, '0};
        tbl[5] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b1, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}};
        tbl[6] = '{1'b1, 16'd0, 1'b1, 1'b0, 1'b0, '0};

        reset_i = 1'b1; empty_i = 1'b1; data_i = '0; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        // reset with a non-empty FIFO: no pop, outputs cleared
        drive(1'b0, 16'h00aa, 1'b1, 1'b1, p);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].e, tbl[i].d, tbl[i].r, 1'b0, p);
            chk($sformatf("tbl%0d_ren", i), {79'd0, ren_o}, {79'd0, tbl[i].x_ren});
            chk($sformatf("tbl%0d_valid", i), {79'd0, valid_o}, {79'd0, tbl[i].x_valid});
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].x_data);
        end

        // empty toggling during a fill
        for (int k = 21; k <= 25; k++) src.push_back(W'(k));
        base_pops = pops;
        for (int i = 0; i < 12; i++) fstep(i % 2 == 0, 1'b1, 1'b0);
        chk("toggle_pops", DW'(pops - base_pops), DW'(5));

        // back-pressure hold for 10 cycles
        for (int k = 31; k <= 40; k++) src.push_back(W'(k));
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            fstep(1'b0, 1'b0, 1'b0);
            got = valid_o;
        end
        chk("hold_rise", {79'd0, got}, {79'd0, 1'b1});
        held = data_o;
        chk("hold_first", held, {16'd35, 16'd34, 16'd33, 16'd32, 16'd31});
        for (int i = 0; i < 10; i++) begin
            fstep(1'b0, 1'b0, 1'b0);
            chk("hold_data", data_o, held);
            chk("hold_valid", {79'd0, valid_o}, {79'd0, 1'b1});
        end
        drain(20);

        // reset after three pops discards the partial vector
        for (int k = 1; k <= 3; k++) src.push_back(W'(k));
        for (int i = 0; i < 3; i++) fstep(1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'h0007, 1'b1, 1'b1, p);
        for (int k = 9; k <= 13; k++) src.push_back(W'(k));
        for (int i = 0; i < 7; i++) fstep(1'b0, 1'b0, 1'b0);
        chk("rst_valid", {79'd0, valid_o}, {79'd0, 1'b1});
        chk("rst_data", data_o, {16'd13, 16'd12, 16'd11, 16'd10, 16'd9});
        drain(10);

`ifdef FC_INPUT_LAYER_DOUBLE_BUFFER_EN
        // continuous stream: vectors on cycles 6, 11, 16 counting the first pop as cycle 1
        for (int k = 1; k <= 15; k++) src.push_back(W'(k));
        for (int i = 0; i < 20; i++) begin
            fstep(1'b0, 1'b1, 1'b0);
            chk($sformatf("stream_valid_c%0d", i + 1), {79'd0, valid_o},
                {79'd0, (i + 1 == 6) || (i + 1 == 11) || (i + 1 == 16)});
        end

        // second vector completes while the first is held
        for (int k = 41; k <= 52; k++) src.push_back(W'(k));
        for (int i = 0; i < 12; i++) fstep(1'b0, 1'b0, 1'b0);
        chk("pend_ren", {79'd0, ren_o}, {79'd0, 1'b0});
        chk("pend_first", data_o, {16'd45, 16'd44, 16'd43, 16'd42, 16'd41});
        fstep(1'b0, 1'b1, 1'b0);
        fstep(1'b1, 1'b0, 1'b0);
        chk("pend_second_valid", {79'd0, valid_o}, {79'd0, 1'b1});
        chk("pend_second", data_o, {16'd50, 16'd49, 16'd48, 16'd47, 16'd46});
        drain(10);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (src.size() < 4) src.push_back(W'($urandom));
            fstep($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
        end
        src.delete();
        drain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
